// File: rtl/cpu_pkg.sv
// Shared CPU definitions: IMEM geometry, NOP encoding, fetch FSM states
// and a saturating counter helper used by the optional fetch counters.
package cpu_pkg;

    localparam int unsigned IMEM_ADDR_W = 14;
    localparam int unsigned INSTR_W     = 32;
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } fetch_state_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/if_pc_gen.sv
// PC generator for the fetch stage. Holds the next fetch address (pc) and
// the address of the read currently in flight (req_addr). A load redirects
// both; an advance moves pc into req_addr and steps pc. Load wins.
module if_pc_gen
    import cpu_pkg::*;
#(
    parameter int unsigned       ADDR_W   = IMEM_ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              advance_i,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] load_addr_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic [ADDR_W-1:0] req_addr_o
);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] req_addr_q, req_addr_d;

    // Next pc / in-flight address; the +1 wraps modulo 2^ADDR_W.
    always_comb begin
        pc_d       = pc_q;
        req_addr_d = req_addr_q;
        if (load_i) begin
            req_addr_d = load_addr_i;
            pc_d       = load_addr_i + ADDR_W'(1);
        end else if (advance_i) begin
            req_addr_d = pc_q;
            pc_d       = pc_q + ADDR_W'(1);
        end
    end

    // Address registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q       <= RESET_PC;
            req_addr_q <= '0;
        end else begin
            pc_q       <= pc_d;
            req_addr_q <= req_addr_d;
        end
    end

    assign pc_o       = pc_q;
    assign req_addr_o = req_addr_q;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage feeding the IF/ID register.
// Drives a 1-cycle-latency synchronous IMEM. A stall parks the returning
// word in a skid register so the pipeline resumes without a bubble; a
// redirect squashes the current output and refetches at the target.
// Handshake: the output {instr_o, addr_o} is consumed on a posedge where
// valid_o=1 and stall_i=0; an unconsumed valid output is presented again
// unchanged next cycle unless redirect_i=1 (which always wins, even over
// stall_i). Optional build macro FETCH_PERF_EN adds saturating counters.
module if_fetch_unit #(
    parameter int unsigned                       ADDR_W    = cpu_pkg::IMEM_ADDR_W,
    parameter logic [ADDR_W-1:0]                 RESET_PC  = '0,
    parameter logic [cpu_pkg::INSTR_W-1:0]       NOP_INSTR = cpu_pkg::NOP_INSTR
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          stall_i,
    input  logic                          redirect_i,
    input  logic [ADDR_W-1:0]             redirect_addr_i,
    output logic                          imem_en_o,
    output logic [ADDR_W-1:0]             imem_addr_o,
    input  logic [cpu_pkg::INSTR_W-1:0]   imem_rdata_i,
    output logic [cpu_pkg::INSTR_W-1:0]   instr_o,
    output logic [ADDR_W-1:0]             addr_o,
    output logic                          valid_o,
`ifdef FETCH_PERF_EN
    output logic [31:0]                   perf_fetch_o,
    output logic [31:0]                   perf_stall_o,
    output logic [31:0]                   perf_redirect_o,
`endif
    output cpu_pkg::fetch_state_t         state_o
);

    import cpu_pkg::*;

    fetch_state_t         state_q, state_d;
    logic [INSTR_W-1:0]   skid_instr_q, skid_instr_d;
    logic [ADDR_W-1:0]    skid_addr_q, skid_addr_d;

    logic                 advance;
    logic                 load;
    logic [ADDR_W-1:0]    pc;
    logic [ADDR_W-1:0]    req_addr;

    logic                 imem_en;
    logic [ADDR_W-1:0]    imem_addr;
    logic                 valid;
    logic [INSTR_W-1:0]   instr;
    logic [ADDR_W-1:0]    addr;

    if_pc_gen #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc_gen (
        .clk         (clk),
        .rst_n       (rst_n),
        .advance_i   (advance),
        .load_i      (load),
        .load_addr_i (redirect_addr_i),
        .pc_o        (pc),
        .req_addr_o  (req_addr)
    );

    // Next-state, skid capture, IMEM request and output mux. Redirect has
    // top priority; reset forces every output quiet while rst_n is low.
    always_comb begin
        state_d      = state_q;
        skid_instr_d = skid_instr_q;
        skid_addr_d  = skid_addr_q;
        advance      = 1'b0;
        load         = 1'b0;
        imem_en      = 1'b0;
        imem_addr    = pc;
        valid        = 1'b0;
        instr        = NOP_INSTR;
        addr         = '0;

        if (redirect_i) begin
            load         = 1'b1;
            imem_en      = 1'b1;
            imem_addr    = redirect_addr_i;
            skid_instr_d = '0;
            skid_addr_d  = '0;
            state_d      = RUN;
        end else begin
            case (state_q)
                BOOT: begin
                    advance = 1'b1;
                    imem_en = 1'b1;
                    state_d = RUN;
                end
                RUN: begin
                    valid = 1'b1;
                    instr = imem_rdata_i;
                    addr  = req_addr;
                    if (stall_i) begin
                        // IMEM output will not be re-read; park it.
                        skid_instr_d = imem_rdata_i;
                        skid_addr_d  = req_addr;
                        state_d      = HOLD;
                    end else begin
                        advance = 1'b1;
                        imem_en = 1'b1;
                    end
                end
                HOLD: begin
                    valid = 1'b1;
                    instr = skid_instr_q;
                    addr  = skid_addr_q;
                    if (!stall_i) begin
                        // Skid is consumed now; the read issued this cycle
                        // supplies the next instruction with no gap.
                        advance = 1'b1;
                        imem_en = 1'b1;
                        state_d = RUN;
                    end
                end
                default: begin
                    state_d = BOOT;
                end
            endcase
        end

        if (!rst_n) begin
            advance = 1'b0;
            load    = 1'b0;
            imem_en = 1'b0;
            valid   = 1'b0;
            instr   = NOP_INSTR;
            addr    = '0;
        end
    end

    // FSM state and skid registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= BOOT;
            skid_instr_q <= '0;
            skid_addr_q  <= '0;
        end else begin
            state_q      <= state_d;
            skid_instr_q <= skid_instr_d;
            skid_addr_q  <= skid_addr_d;
        end
    end

    assign imem_en_o   = imem_en;
    assign imem_addr_o = imem_addr;
    assign valid_o     = valid;
    assign instr_o     = instr;
    assign addr_o      = addr;
    assign state_o     = state_q;

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch_q, perf_fetch_d;
    logic [31:0] perf_stall_q, perf_stall_d;
    logic [31:0] perf_redirect_q, perf_redirect_d;

    // Saturating event counts: consumed instructions, stalled-valid
    // cycles, and redirects seen outside reset.
    always_comb begin
        perf_fetch_d    = perf_fetch_q;
        perf_stall_d    = perf_stall_q;
        perf_redirect_d = perf_redirect_q;
        if (valid && !stall_i) perf_fetch_d    = sat_inc(perf_fetch_q);
        if (valid && stall_i)  perf_stall_d    = sat_inc(perf_stall_q);
        if (redirect_i)        perf_redirect_d = sat_inc(perf_redirect_q);
    end

    // Counter registers, cleared by reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_fetch_q    <= '0;
            perf_stall_q    <= '0;
            perf_redirect_q <= '0;
        end else begin
            perf_fetch_q    <= perf_fetch_d;
            perf_stall_q    <= perf_stall_d;
            perf_redirect_q <= perf_redirect_d;
        end
    end

    assign perf_fetch_o    = perf_fetch_q;
    assign perf_stall_o    = perf_stall_q;
    assign perf_redirect_o = perf_redirect_q;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed vector table followed by randomized
// traffic checked against a stream-level reference model.
module tb_if_fetch_unit;
    import cpu_pkg::*;

    localparam int unsigned AW = 14;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          stall_i;
    logic          redirect_i;
    logic [AW-1:0] redirect_addr_i;
    logic          imem_en_o;
    logic [AW-1:0] imem_addr_o;
    logic [31:0]   imem_rdata_i;
    logic [31:0]   instr_o;
    logic [AW-1:0] addr_o;
    logic          valid_o;
    fetch_state_t  state_o;
`ifdef FETCH_PERF_EN
    logic [31:0]   perf_fetch_o;
    logic [31:0]   perf_stall_o;
    logic [31:0]   perf_redirect_o;
`endif

    // Clock.
    always #5 clk = ~clk;

    if_fetch_unit dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .stall_i         (stall_i),
        .redirect_i      (redirect_i),
        .redirect_addr_i (redirect_addr_i),
        .imem_en_o       (imem_en_o),
        .imem_addr_o     (imem_addr_o),
        .imem_rdata_i    (imem_rdata_i),
        .instr_o         (instr_o),
        .addr_o          (addr_o),
        .valid_o         (valid_o),
`ifdef FETCH_PERF_EN
        .perf_fetch_o    (perf_fetch_o),
        .perf_stall_o    (perf_stall_o),
        .perf_redirect_o (perf_redirect_o),
`endif
        .state_o         (state_o)
    );

    // Synchronous IMEM: word at addr reads as 0xA000_0000 | addr.
    initial imem_rdata_i = 32'h0;
    always @(posedge clk) begin
        if (imem_en_o) imem_rdata_i <= 32'hA000_0000 | 32'(imem_addr_o);
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Reference model of the output stream: what IF/ID should see next,
    // and the next sequential fetch address.
    logic          m_out_valid;
    logic [AW-1:0] m_out_addr;
    logic [AW-1:0] m_pc;
    logic [31:0]   m_fetch, m_stall, m_redir;

    task automatic model_reset();
        m_out_valid = 1'b0;
        m_out_addr  = '0;
        m_pc        = '0;
        m_fetch     = 0;
        m_stall     = 0;
        m_redir     = 0;
    endtask

    task automatic model_step(input logic r, input logic s, input logic d, input logic [AW-1:0] ra);
        if (!r) begin
            model_reset();
        end else begin
            if (d) m_redir++;
            else if (m_out_valid && s) m_stall++;
            else if (m_out_valid) m_fetch++;
            if (d) begin
                m_out_valid = 1'b1;
                m_out_addr  = ra;
                m_pc        = ra + AW'(1);
            end else if (!m_out_valid || !s) begin
                m_out_valid = 1'b1;
                m_out_addr  = m_pc;
                m_pc        = m_pc + AW'(1);
            end
        end
    endtask

    task automatic drive(input logic r, input logic s, input logic d, input logic [AW-1:0] ra);
        @(negedge clk);
        rst_n           = r;
        stall_i         = s;
        redirect_i      = d;
        redirect_addr_i = ra;
        #1;
    endtask

    // Compare DUT outputs for the current cycle against given expectations.
    task automatic chk_outputs(input logic r, input logic ev, input logic [AW-1:0] ea,
                               input logic een, input logic [AW-1:0] eia);
        chk("valid_o", 32'(valid_o), 32'(ev));
        if (ev) begin
            chk("addr_o", 32'(addr_o), 32'(ea));
            chk("instr_o", instr_o, 32'hA000_0000 | 32'(ea));
        end else begin
            chk("instr_o_nop", instr_o, NOP);
        end
        if (!r) chk("addr_o_rst", 32'(addr_o), 32'h0);
        chk("imem_en_o", 32'(imem_en_o), 32'(een));
        if (een) chk("imem_addr_o", 32'(imem_addr_o), 32'(eia));
    endtask

    typedef struct {
        logic          rst;
        logic          stall;
        logic          redir;
        logic [AW-1:0] raddr;
        logic          e_valid;
        logic [AW-1:0] e_addr;
        logic          e_en;
        logic [AW-1:0] e_iaddr;
    } vec_t;

    localparam int NV = 29;
    vec_t tbl[NV];

    function automatic vec_t mk(input logic r, input logic s, input logic d, input logic [AW-1:0] ra,
                                input logic ev, input logic [AW-1:0] ea, input logic een,
                                input logic [AW-1:0] eia);
        vec_t v;
        v.rst = r; v.stall = s; v.redir = d; v.raddr = ra;
        v.e_valid = ev; v.e_addr = ea; v.e_en = een; v.e_iaddr = eia;
        return v;
    endfunction

    initial begin
        rst_n = 1'b0; stall_i = 1'b0; redirect_i = 1'b0; redirect_addr_i = '0;
        model_reset();

        //            rst stl red raddr    valid addr     en  imem_addr
        tbl[0]  = mk(0, 0, 0, 14'h0000, 0, 14'h0000, 0, 14'h0000);
        tbl[1]  = mk(0, 0, 0, 14'h0000, 0, 14'h0000, 0, 14'h0000);
        tbl[2]  = mk(1, 0, 0, 14'h0000, 0, 14'h0000, 1, 14'h0000); // boot
        tbl[3]  = mk(1, 0, 0, 14'h0000, 1, 14'h0000, 1, 14'h0001);
        tbl[4]  = mk(1, 0, 0, 14'h0000, 1, 14'h0001, 1, 14'h0002);
        tbl[5]  = mk(1, 0, 0, 14'h0000, 1, 14'h0002, 1, 14'h0003);
        tbl[6]  = mk(1, 0, 0, 14'h0000, 1, 14'h0003, 1, 14'h0004);
        tbl[7]  = mk(1, 0, 0, 14'h0000, 1, 14'h0004, 1, 14'h0005);
        tbl[8]  = mk(1, 1, 0, 14'h0000, 1, 14'h0005, 0, 14'h0000); // stall x3
        tbl[9]  = mk(1, 1, 0, 14'h0000, 1, 14'h0005, 0, 14'h0000);
        tbl[10] = mk(1, 1, 0, 14'h0000, 1, 14'h0005, 0, 14'h0000);
        tbl[11] = mk(1, 0, 0, 14'h0000, 1, 14'h0005, 1, 14'h0006);
        tbl[12] = mk(1, 0, 0, 14'h0000, 1, 14'h0006, 1, 14'h0007);
        tbl[13] = mk(1, 0, 1, 14'h0100, 0, 14'h0000, 1, 14'h0100); // redirect
        tbl[14] = mk(1, 0, 0, 14'h0000, 1, 14'h0100, 1, 14'h0101);
        tbl[15] = mk(1, 1, 0, 14'h0000, 1, 14'h0101, 0, 14'h0000);
        tbl[16] = mk(1, 1, 1, 14'h0040, 0, 14'h0000, 1, 14'h0040); // redirect in HOLD
        tbl[17] = mk(1, 0, 0, 14'h0000, 1, 14'h0040, 1, 14'h0041);
        tbl[18] = mk(1, 0, 1, 14'h3FFE, 0, 14'h0000, 1, 14'h3FFE); // wrap
        tbl[19] = mk(1, 0, 0, 14'h0000, 1, 14'h3FFE, 1, 14'h3FFF);
        tbl[20] = mk(1, 0, 0, 14'h0000, 1, 14'h3FFF, 1, 14'h0000);
        tbl[21] = mk(1, 0, 0, 14'h0000, 1, 14'h0000, 1, 14'h0001);
        tbl[22] = mk(1, 1, 0, 14'h0000, 1, 14'h0001, 0, 14'h0000);
        tbl[23] = mk(1, 1, 0, 14'h0000, 1, 14'h0001, 0, 14'h0000);
        tbl[24] = mk(0, 1, 0, 14'h0000, 0, 14'h0000, 0, 14'h0000); // reset mid-HOLD
        tbl[25] = mk(0, 0, 0, 14'h0000, 0, 14'h0000, 0, 14'h0000);
        tbl[26] = mk(1, 0, 0, 14'h0000, 0, 14'h0000, 1, 14'h0000);
        tbl[27] = mk(1, 0, 0, 14'h0000, 1, 14'h0000, 1, 14'h0001);
        tbl[28] = mk(1, 0, 0, 14'h0000, 1, 14'h0001, 1, 14'h0002);

        // Directed table.
        for (int i = 0; i < NV; i++) begin
            drive(tbl[i].rst, tbl[i].stall, tbl[i].redir, tbl[i].raddr);
            chk_outputs(tbl[i].rst, tbl[i].e_valid, tbl[i].e_addr, tbl[i].e_en, tbl[i].e_iaddr);
`ifdef FETCH_PERF_EN
            if (i == 2 || i == 26) begin
                chk("perf_fetch_rst", perf_fetch_o, 32'd0);
                chk("perf_stall_rst", perf_stall_o, 32'd0);
                chk("perf_redirect_rst", perf_redirect_o, 32'd0);
            end
            if (i == 11) begin
                chk("perf_stall_after_stall", perf_stall_o, 32'd3);
                chk("perf_fetch_after_stall", perf_fetch_o, 32'd5);
            end
`endif
            model_step(tbl[i].rst, tbl[i].stall, tbl[i].redir, tbl[i].raddr);
        end

        // Randomized traffic against the reference model.
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 1'b0, 1'b0, '0);
            model_step(1'b0, 1'b0, 1'b0, '0);
        end
        for (int i = 0; i < 1500; i++) begin
            logic          r, s, d, een, ev;
            logic [AW-1:0] ra, eia;
            r  = ($urandom_range(0, 99) != 0);
            s  = ($urandom_range(0, 2) == 0);
            d  = ($urandom_range(0, 9) == 0);
            ra = ($urandom_range(0, 3) == 0) ? AW'(14'h3FFC + AW'($urandom_range(0, 3)))
                                             : AW'($urandom);
            drive(r, s, d, ra);
            if (!r) begin
                ev = 1'b0; een = 1'b0; eia = '0;
            end else if (d) begin
                ev = 1'b0; een = 1'b1; eia = ra;
            end else begin
                ev  = m_out_valid;
                een = !(m_out_valid && s);
                eia = m_pc;
            end
            chk_outputs(r, ev, m_out_addr, een, eia);
`ifdef FETCH_PERF_EN
            chk("perf_fetch", perf_fetch_o, m_fetch);
            chk("perf_stall", perf_stall_o, m_stall);
            chk("perf_redirect", perf_redirect_o, m_redir);
`endif
            model_step(r, s, d, ra);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
